// File: rtl/aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_pipe
// Description : Handshaked AES-128 encryption round engine. Performs
//               SubBytes, ShiftRows, MixColumns and AddRoundKey over a
//               1-, 2- or 3-register elastic pipeline. A per-transaction
//               final flag skips MixColumns; key, flags and a user tag
//               travel alongside the state.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready  - input handshake
//               in_data, in_key    - round state and round key (128 b)
//               in_final, in_init  - skip MixColumns / AddRoundKey only
//               in_tag             - sideband tag (TAG_W b)
//               out_valid/out_ready- output handshake
//               out_data, out_tag  - registered round result and tag
// Config      : AES_ROUND_INIT_MODE_EN - when defined, in_init selects
//               out = in_data ^ in_key (priority over in_final); otherwise
//               in_init is ignored and no init flag is stored.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [127:0]     in_key,
    input  logic             in_final,
    input  logic             in_init,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
            $fatal(1, "aes_round_pipe: STAGES must be 1, 2 or 3");
        end
    endgenerate

    // Stage index at which each round step is applied.
    localparam int c_SB_AT  = 0;
    localparam int c_SR_AT  = (STAGES == 3) ? 1 : 0;
    localparam int c_MC_AT  = (STAGES == 1) ? 0 : 1;
    localparam int c_ARK_AT = STAGES - 1;

    localparam logic [7:0] c_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte k of the state lives at [127-8k -: 8]; byte 4c+r is row r, column c.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = c_SBOX[s[127-8*k -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Applies whichever round steps are mapped onto stage idx. An init
    // transaction bypasses everything except the key XOR.
    function automatic logic [127:0] stage_fn(input int idx, input logic [127:0] d,
                                              input logic [127:0] k, input logic fin,
                                              input logic ini);
        logic [127:0] s;
        s = d;
        if (!ini) begin
            if (idx == c_SB_AT) s = sub_bytes(s);
            if (idx == c_SR_AT) s = shift_rows(s);
            if (idx == c_MC_AT && !fin) s = mix_columns(s);
        end
        if (idx == c_ARK_AT) s = s ^ k;
        return s;
    endfunction

    logic [STAGES-1:0]              r_vld, r_fin;
    logic [STAGES-1:0][127:0]       r_data, r_key;
    logic [STAGES-1:0][TAG_W-1:0]   r_tag;
    logic [STAGES-1:0]              w_ready, w_src_vld, w_src_fin, w_src_ini;
    logic [STAGES-1:0][127:0]       w_src_data, w_src_key, w_nxt_data;
    logic [STAGES-1:0][TAG_W-1:0]   w_src_tag;

`ifdef AES_ROUND_INIT_MODE_EN
    logic [STAGES-1:0] r_ini;
    logic              w_unused_ini_tail;
    assign w_unused_ini_tail = r_ini[STAGES-1];
`else
    logic w_unused_init;
    assign w_unused_init = in_init;
`endif

    // The last stage's key and final flag have no consumer downstream.
    logic w_unused_tail;
    assign w_unused_tail = (^r_key[STAGES-1]) ^ r_fin[STAGES-1];

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            // A stage can take new content if any stage at or after it has a
            // hole, or the output is popped: a full tail then shifts as one.
            assign w_ready[i] = ~(&r_vld[STAGES-1:i]) | out_ready;

            if (i == 0) begin : g_head
                assign w_src_vld[i]  = in_valid;
                assign w_src_data[i] = in_data;
                assign w_src_key[i]  = in_key;
                assign w_src_fin[i]  = in_final;
                assign w_src_tag[i]  = in_tag;
`ifdef AES_ROUND_INIT_MODE_EN
                assign w_src_ini[i]  = in_init;
`else
                assign w_src_ini[i]  = 1'b0;
`endif
            end else begin : g_body
                assign w_src_vld[i]  = r_vld[i-1];
                assign w_src_data[i] = r_data[i-1];
                assign w_src_key[i]  = r_key[i-1];
                assign w_src_fin[i]  = r_fin[i-1];
                assign w_src_tag[i]  = r_tag[i-1];
`ifdef AES_ROUND_INIT_MODE_EN
                assign w_src_ini[i]  = r_ini[i-1];
`else
                assign w_src_ini[i]  = 1'b0;
`endif
            end

            assign w_nxt_data[i] = stage_fn(i, w_src_data[i], w_src_key[i],
                                            w_src_fin[i], w_src_ini[i]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_data <= '0;
            r_key  <= '0;
            r_fin  <= '0;
            r_tag  <= '0;
`ifdef AES_ROUND_INIT_MODE_EN
            r_ini  <= '0;
`endif
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_vld[i] <= w_src_vld[i];
                    // Payload only moves with a real transaction, so a
                    // bubble never disturbs the held data.
                    if (w_src_vld[i]) begin
                        r_data[i] <= w_nxt_data[i];
                        r_key[i]  <= w_src_key[i];
                        r_fin[i]  <= w_src_fin[i];
                        r_tag[i]  <= w_src_tag[i];
`ifdef AES_ROUND_INIT_MODE_EN
                        r_ini[i]  <= w_src_ini[i];
`endif
                    end
                end
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_vld[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_pipe
// Description : Self-checking bench for aes_round_pipe. Three instances
//               (STAGES = 1, 2, 3) share the payload inputs; each has its
//               own handshake and its own expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_pipe;

    localparam int TAG_W = 4;
    localparam int NI    = 3;

    typedef struct {
        logic [127:0]     data;
        logic [TAG_W-1:0] tag;
        int               acc;
        bit               chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [NI-1:0]      in_valid, in_ready, out_valid, out_ready;
    logic [127:0]       in_data, in_key;
    logic               in_final, in_init;
    logic [TAG_W-1:0]   in_tag;
    logic [127:0]       out_data [NI];
    logic [TAG_W-1:0]   out_tag  [NI];

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            aes_round_pipe #(.STAGES(g + 1), .TAG_W(TAG_W)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_data   (in_data),
                .in_key    (in_key),
                .in_final  (in_final),
                .in_init   (in_init),
                .in_tag    (in_tag),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g]),
                .out_tag   (out_tag[g])
            );
        end
    endgenerate

    int               n_assert = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    bit               lat_mode;
    logic [127:0]     drv_exp;
    exp_t             q0[$], q1[$], q2[$];
    logic [7:0]       sbox_tab [256];
    int               fire_cnt [NI];
    bit               prev_stall [NI];
    logic [127:0]     prev_data [NI];
    logic [TAG_W-1:0] prev_tag [NI];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (computed S-box) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, x);
            sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k,
                                               input logic fin, input logic ini);
        logic [7:0]   st [4][4];
        logic [7:0]   t  [4][4];
        logic [127:0] r;
`ifdef AES_ROUND_INIT_MODE_EN
        if (ini) return d ^ k;
`else
        if (ini && 1'b0) return d;
`endif
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                st[rw][c] = sbox_tab[d[127-8*(4*c+rw) -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[rw][c] = st[rw][(c + rw) % 4];
        for (int c = 0; c < 4; c++) begin
            if (fin) begin
                for (int rw = 0; rw < 4; rw++) st[rw][c] = t[rw][c];
            end else begin
                st[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
                st[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
                st[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
                st[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
            end
        end
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[127-8*(4*c+rw) -: 8] = st[rw][c];
        return r ^ k;
    endfunction

    // ---------------- scoreboard ----------------
    function automatic int sb_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int i, output exp_t e, output bit ok);
        ok = (sb_size(i) != 0);
        if (ok) begin
            case (i)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    // Called at a falling edge with inputs already driven; evaluates the
    // handshakes that the next rising edge will perform.
    task automatic tick();
        exp_t e;
        bit   ok;
        #1;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                prev_stall[i] = 1'b0;
            end else begin
                if (prev_stall[i]) begin
                    chk($sformatf("hold_data_s%0d", i + 1), out_data[i], prev_data[i]);
                    chk($sformatf("hold_tag_s%0d", i + 1), 128'(out_tag[i]), 128'(prev_tag[i]));
                end
                prev_stall[i] = out_valid[i] & ~out_ready[i];
                prev_data[i]  = out_data[i];
                prev_tag[i]   = out_tag[i];
                if (out_valid[i] & out_ready[i]) begin
                    fire_cnt[i]++;
                    sb_pop(i, e, ok);
                    chk($sformatf("expected_pending_s%0d", i + 1), 128'(ok), 128'(1));
                    if (ok) begin
                        chk($sformatf("data_s%0d", i + 1), out_data[i], e.data);
                        chk($sformatf("tag_s%0d", i + 1), 128'(out_tag[i]), 128'(e.tag));
                        if (e.chk_lat)
                            chk($sformatf("latency_s%0d", i + 1), 128'(cyc - e.acc), 128'(i + 1));
                    end
                end
                if (in_valid[i] & in_ready[i]) begin
                    e.data    = drv_exp;
                    e.tag     = in_tag;
                    e.acc     = cyc;
                    e.chk_lat = lat_mode;
                    sb_push(i, e);
                end
            end
        end
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_tx(input logic [127:0] d, input logic [127:0] k, input logic fin,
                          input logic ini, input logic [TAG_W-1:0] tag, input logic [127:0] exp);
        in_data  = d;
        in_key   = k;
        in_final = fin;
        in_init  = ini;
        in_tag   = tag;
        drv_exp  = exp;
    endtask

    task automatic load_rand(input logic [TAG_W-1:0] tag);
        logic [127:0] d, k;
        logic         fin, ini;
        d   = {$urandom, $urandom, $urandom, $urandom};
        k   = {$urandom, $urandom, $urandom, $urandom};
        fin = 1'($urandom_range(0, 1));
        ini = ($urandom_range(0, 3) == 0);
        set_tx(d, k, fin, ini, tag, ref_round(d, k, fin, ini));
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = '1;
        for (int t = 0; t < 40 && (sb_size(0) + sb_size(1) + sb_size(2)) != 0; t++) tick();
        chk("drain_empty", 128'(sb_size(0) + sb_size(1) + sb_size(2)), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           sent;
        bit           acc;
        int           base [NI];
        logic [127:0] exp_init;

        build_sbox();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        lat_mode  = 1'b0;
        set_tx('0, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < NI; i++) begin
            fire_cnt[i]   = 0;
            prev_stall[i] = 1'b0;
        end

        // Reset state
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_out_valid_s%0d", i + 1), 128'(out_valid[i]), 128'(0));
            chk($sformatf("rst_out_data_s%0d", i + 1), out_data[i], 128'(0));
            chk($sformatf("rst_out_tag_s%0d", i + 1), 128'(out_tag[i]), 128'(0));
            chk($sformatf("rst_in_ready_s%0d", i + 1), 128'(in_ready[i]), 128'(1));
        end
        tick();

        // Known-answer vectors, back to back, latency checked
`ifdef AES_ROUND_INIT_MODE_EN
        exp_init = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`else
        exp_init = ref_round(128'h3243f6a8885a308d313198a2e0370734,
                             128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b0);
`endif
        out_ready = '1;
        lat_mode  = 1'b1;
        in_valid  = '1;
        set_tx(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'ha0fafe1788542cb123a339392a6c7605,
               1'b0, 1'b0, 4'd1, 128'ha49c7ff2689f352b6b5bea43026a5049);
        tick();
        set_tx(128'heb40f21e592e38848ba113e71bc342d2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
               1'b1, 1'b0, 4'd2, 128'h3925841d02dc09fbdc118597196a0b32);
        tick();
        set_tx(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               1'b1, 1'b1, 4'd3, exp_init);
        tick();
        drain();

        // Backpressure on the 3-stage instance
        lat_mode    = 1'b0;
        out_ready   = 3'b011;
        in_valid    = '0;
        sent        = 0;
        load_rand(4'd0);
        for (int t = 0; t < 300 && (sent < 8 || sb_size(2) != 0); t++) begin
            out_ready[2] = (t < 5) ? 1'b0 : 1'($urandom_range(0, 1));
            in_valid[2]  = (sent < 8);
            #1;
            if (t < 5) chk("fill_in_ready_s3", 128'(in_ready[2]), 128'(sent < 3));
            acc = in_valid[2] & in_ready[2];
            tick();
            if (acc) begin
                sent++;
                if (sent < 8) load_rand(4'(sent));
            end
        end
        chk("bp_sent", 128'(sent), 128'(8));
        chk("bp_drained", 128'(sb_size(2)), 128'(0));
        drain();

        // Reset with transactions in flight
        lat_mode  = 1'b1;
        out_ready = '1;
        in_valid  = '1;
        load_rand(4'd9);
        tick();
        load_rand(4'd10);
        tick();
        rst_n = 1'b0;
        load_rand(4'd11);
        tick();
        rst_n    = 1'b1;
        in_valid = '0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("mid_rst_out_valid_s%0d", i + 1), 128'(out_valid[i]), 128'(0));
            chk($sformatf("mid_rst_out_data_s%0d", i + 1), out_data[i], 128'(0));
            chk($sformatf("mid_rst_in_ready_s%0d", i + 1), 128'(in_ready[i]), 128'(1));
        end
        repeat (6) tick();

        // Full throughput, 100 back to back
        for (int i = 0; i < NI; i++) base[i] = fire_cnt[i];
        in_valid = '1;
        for (int j = 0; j < 100; j++) begin
            load_rand(4'(j));
            #1;
            chk("tp_in_ready", 128'(in_ready), 128'(3'b111));
            tick();
        end
        drain();
        for (int i = 0; i < NI; i++)
            chk($sformatf("tp_count_s%0d", i + 1), 128'(fire_cnt[i] - base[i]), 128'(100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
